alu: RTL and testbench

//   8-bit combinational ALU datapath with registered result and status flags for the 8-bit CPU.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_addsub.sv | 23 ++
 rtl/alu.sv | 132 +++++++++++++
 tb/tb_alu.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and status-flag bit positions for the 8-bit CPU ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_INC   = 4'h2;
   localparam logic [3:0] OP_DEC   = 4'h3;
   localparam logic [3:0] OP_AND   = 4'h4;
   localparam logic [3:0] OP_OR    = 4'h5;
   localparam logic [3:0] OP_XOR   = 4'h6;
   localparam logic [3:0] OP_NOT   = 4'h7;
   localparam logic [3:0] OP_SHL   = 4'h8;
   localparam logic [3:0] OP_SHR   = 4'h9;
   localparam logic [3:0] OP_ASR   = 4'hA;
   localparam logic [3:0] OP_ROL   = 4'hB;
   localparam logic [3:0] OP_ROR   = 4'hC;
   localparam logic [3:0] OP_PASSA = 4'hD;
   localparam logic [3:0] OP_PASSB = 4'hE;
   localparam logic [3:0] OP_NEG   = 4'hF;

   localparam int FLG_C = 0;
   localparam int FLG_Z = 1;
   localparam int FLG_N = 2;
   localparam int FLG_V = 3;
   localparam int FLG_P = 4;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor: sum = x + (sub ? ~y : y) + cin, with raw carry out and signed overflow.
module alu_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             sub,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH-1:0] y_eff;

   always_comb begin
      y_eff       = sub ? ~y : y;
      {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, cin};
      // overflow: both effective operands share a sign that the sum does not
      ovf         = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
   end

endmodule

// File: rtl/alu.sv
// 8-bit ALU: opcode mux around a shared adder/subtractor, flag generation, and a one-cycle output register.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic [WIDTH-1:0] z,
   output logic [7:0]       flag
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] as_x;
   logic [WIDTH-1:0] as_y;
   logic             as_sub;
   logic             as_cin;
   logic [WIDTH-1:0] as_sum;
   logic             as_cout;
   logic             as_ovf;

   logic [WIDTH-1:0] r;
   logic             c_nxt;
   logic             v_nxt;
   logic [7:0]       flag_nxt;

   always_comb begin
      as_x   = a;
      as_y   = b;
      as_sub = 1'b0;
      as_cin = 1'b0;
      case (sel)
         OP_SUB: begin
            as_sub = 1'b1;
            as_cin = 1'b1;
         end
         OP_INC: as_y = ONE;
         OP_DEC: begin
            as_y   = ONE;
            as_sub = 1'b1;
            as_cin = 1'b1;
         end
         OP_NEG: begin
            as_x   = '0;
            as_y   = a;
            as_sub = 1'b1;
            as_cin = 1'b1;
         end
         default: ;
      endcase
   end

   alu_addsub #(.WIDTH(WIDTH)) u_addsub (
      .x    (as_x),
      .y    (as_y),
      .sub  (as_sub),
      .cin  (as_cin),
      .sum  (as_sum),
      .cout (as_cout),
      .ovf  (as_ovf)
   );

   // subtract paths report borrow, which is the inverse of the adder carry
   always_comb begin
      r     = '0;
      c_nxt = 1'b0;
      v_nxt = 1'b0;
      case (sel)
         OP_ADD, OP_INC: begin
            r     = as_sum;
            c_nxt = as_cout;
            v_nxt = as_ovf;
         end
         OP_SUB, OP_DEC, OP_NEG: begin
            r     = as_sum;
            c_nxt = ~as_cout;
            v_nxt = as_ovf;
         end
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_XOR:   r = a ^ b;
         OP_NOT:   r = ~a;
         OP_SHL: begin
            r     = {a[WIDTH-2:0], 1'b0};
            c_nxt = a[WIDTH-1];
         end
         OP_SHR: begin
            r     = {1'b0, a[WIDTH-1:1]};
            c_nxt = a[0];
         end
         OP_ASR: begin
            r     = {a[WIDTH-1], a[WIDTH-1:1]};
            c_nxt = a[0];
         end
         OP_ROL: begin
            r     = {a[WIDTH-2:0], a[WIDTH-1]};
            c_nxt = a[WIDTH-1];
         end
         OP_ROR: begin
            r     = {a[0], a[WIDTH-1:1]};
            c_nxt = a[0];
         end
         OP_PASSA: r = a;
         OP_PASSB: r = b;
         default:  r = '0;
      endcase
   end

   always_comb begin
      flag_nxt        = '0;
      flag_nxt[FLG_C] = c_nxt;
      flag_nxt[FLG_Z] = (r == '0);
      flag_nxt[FLG_N] = r[WIDTH-1];
      flag_nxt[FLG_V] = v_nxt;
      flag_nxt[FLG_P] = ^r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         z    <= '0;
         flag <= '0;
      end else begin
         z    <= r;
         flag <= flag_nxt;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Randomized and directed bench for alu against an integer-arithmetic reference model.
module tb_alu;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] sel;
   logic [7:0] z;
   logic [7:0] flag;

   int n_checks = 0;
   int n_fail   = 0;

   alu #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .sel  (sel),
      .z    (z),
      .flag (flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // returns {flag, z} computed with plain integer arithmetic
   function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic [3:0] ms);
      int ia, ib, sa, sb, res, sres, r, ones;
      logic c, v, p;
      ia = ma; ib = mb;
      sa = $signed(ma); sb = $signed(mb);
      c = 0; v = 0; res = 0;
      case (ms)
         4'h0: begin res = ia + ib; c = (res > 255); sres = sa + sb; v = (sres > 127 || sres < -128); end
         4'h1: begin res = ia - ib; c = (ia < ib);   sres = sa - sb; v = (sres > 127 || sres < -128); end
         4'h2: begin res = ia + 1; c = (ia == 255); v = (ia == 127); end
         4'h3: begin res = ia - 1; c = (ia == 0);   v = (ia == 128); end
         4'h4: res = ia & ib;
         4'h5: res = ia | ib;
         4'h6: res = ia ^ ib;
         4'h7: res = 255 - ia;
         4'h8: begin res = ia * 2; c = (ia >= 128); end
         4'h9: begin res = ia / 2; c = (ia % 2 == 1); end
         4'hA: begin res = ia / 2 + ((ia >= 128) ? 128 : 0); c = (ia % 2 == 1); end
         4'hB: begin res = ia * 2 + ia / 128; c = (ia >= 128); end
         4'hC: begin res = ia / 2 + (ia % 2) * 128; c = (ia % 2 == 1); end
         4'hD: res = ia;
         4'hE: res = ib;
         default: begin res = 0 - ia; c = (ia != 0); v = (ia == 128); end
      endcase
      r = res & 255;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += (r >> i) & 1;
      p = (ones % 2 == 1);
      model = {3'b000, p, v, (r >= 128), (r == 0), c, r[7:0]};
   endfunction

   task automatic step(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] ts);
      a = ta; b = tb_; sel = ts;
      @(posedge clk);
      #1;
   endtask

   task automatic step_chk(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                           input logic [3:0] ts);
      step(ta, tb_, ts);
      chk(tag, {flag, z}, model(ta, tb_, ts));
   endtask

   logic [7:0]  sweep_z [16];
   logic [15:0] held;
   logic [7:0]  ra, rb;
   logic [3:0]  rs;

   initial begin
      sweep_z = '{8'hB6, 8'h50, 8'h84, 8'h82, 8'h03, 8'hB3, 8'hB0, 8'h7C,
                  8'h06, 8'h41, 8'hC1, 8'h07, 8'hC1, 8'h83, 8'h33, 8'h7D};
      rst = 1'b1; a = 8'hFF; b = 8'h01; sel = 4'h0;
      @(posedge clk); #1;
      step(8'h7F, 8'h01, 4'h0);
      chk("reset", {flag, z}, 16'h0000);

      rst = 1'b0;
      for (int s = 0; s < 16; s++) begin
         step(8'h83, 8'h33, 4'(s));
         chk($sformatf("sweep_z_%0h", s), {8'h00, z}, {8'h00, sweep_z[s]});
         chk($sformatf("sweep_f_%0h", s), {8'h00, flag}, {8'h00, model(8'h83, 8'h33, 4'(s)) >> 8});
         if (s == 0)  chk("sweep_add_ncv", {13'd0, flag[2], flag[0], flag[3]}, 16'b100);
         if (s == 1)  chk("sweep_sub_cv",  {14'd0, flag[0], flag[3]}, 16'b01);
         if (s >= 8 && s <= 12) chk($sformatf("sweep_shift_c_%0h", s), {15'd0, flag[0]}, 16'd1);
         if (s == 15) chk("sweep_neg_cn", {14'd0, flag[0], flag[2]}, 16'b10);
      end

      step(8'hFF, 8'h01, 4'h0);
      chk("add_ff_01", {flag, z}, {8'b0000_0011, 8'h00});
      step(8'h7F, 8'h01, 4'h0);
      chk("add_7f_01", {flag[3], flag[2], 6'd0, z}, {2'b11, 6'd0, 8'h80});
      step(8'h00, 8'h01, 4'h1);
      chk("sub_00_01", {flag[0], flag[2], 6'd0, z}, {2'b11, 6'd0, 8'hFF});
      step(8'h80, 8'h01, 4'h1);
      chk("sub_80_01", {flag[3], 7'd0, z}, {1'b1, 7'd0, 8'h7F});
      step(8'h5A, 8'h5A, 4'h6);
      chk("xor_eq", {flag[1], flag[4], 6'd0, z}, {2'b10, 6'd0, 8'h00});
      step(8'h07, 8'hC4, 4'hD);
      chk("passa_par", {15'd0, flag[4]}, 16'd1);
      step_chk("inc_ff", 8'hFF, 8'h12, 4'h2);
      step_chk("inc_7f", 8'h7F, 8'h12, 4'h2);
      step_chk("dec_00", 8'h00, 8'h12, 4'h3);
      step_chk("dec_80", 8'h80, 8'h12, 4'h3);
      step_chk("neg_80", 8'h80, 8'h00, 4'hF);
      step_chk("neg_00", 8'h00, 8'hFF, 4'hF);

      // reset in the middle of a sweep, then resume
      step_chk("pre_rst", 8'hA5, 8'h3C, 4'h0);
      rst = 1'b1;
      step(8'hA5, 8'h3C, 4'h5);
      chk("mid_rst", {flag, z}, 16'h0000);
      rst = 1'b0;
      step_chk("post_rst", 8'hA5, 8'h3C, 4'h6);

      // latency: a select change between edges must not reach z before the next posedge
      step_chk("lat_a", 8'h01, 8'h02, 4'h0);
      held = {flag, z};
      sel = 4'h1;
      @(negedge clk);
      chk("lat_hold", {flag, z}, held);
      @(posedge clk); #1;
      chk("lat_new", {flag, z}, model(8'h01, 8'h02, 4'h1));

      for (int i = 0; i < 400; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 4'($urandom_range(15, 0));
         if (i % 50 == 7) ra = 8'h80;
         if (i % 50 == 23) rb = ra;
         step_chk($sformatf("rand_%0d_op%0h", i, rs), ra, rb, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
